// File: rtl/mem_bus_pkg.sv
// Shared definitions for the firmware-RAM arbiter: FSM state codes, grant
// encodings, the selected-request bundle and the address range helper.
package mem_bus_pkg;

  // Access sequencer states; IDLE is the only state that can last more than one cycle.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // A zero strobe pattern marks a read on the picorv32 native bus.
  localparam logic [3:0] WSTRB_READ = 4'b0000;

  // One-hot owner encodings.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_R0   = 2'b01;
  localparam logic [1:0] GNT_R1   = 2'b10;

  // The request fields of whichever requester wins arbitration.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // True when the word addressed by a byte address lies inside the RAM;
  // the two byte-offset bits play no part in the decision.
  function automatic logic word_in_range(input logic [31:0] byte_addr,
                                         input logic [31:0] depth);
    return ({2'b00, byte_addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. A lone request always wins; when both request,
// the requester that did not win the previous contention is chosen.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and the previous contention winner.
  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_R0;
      2'b10:   gnt = GNT_R1;
      2'b11: begin
        if (last) begin
          gnt = GNT_R0;
        end else begin
          gnt = GNT_R1;
        end
      end
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one synchronous single-port RAM between two picorv32 native memory
// ports. Each access runs IDLE -> ISSUE -> CAPTURE -> DONE; the RAM is only
// driven during ISSUE and the owner gets a single-cycle ready in DONE.
module shared_mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter  int MEM_SIZE = 4096,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          r0_valid,
  input  logic [31:0]   r0_addr,
  input  logic [31:0]   r0_wdata,
  input  logic [3:0]    r0_wstrb,
  output logic          r0_ready,
  output logic [31:0]   r0_rdata,
  input  logic          r1_valid,
  input  logic [31:0]   r1_addr,
  input  logic [31:0]   r1_wdata,
  input  logic [3:0]    r1_wstrb,
  output logic          r1_ready,
  output logic [31:0]   r1_rdata,
  output logic          m_en,
  output logic [3:0]    m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  output logic [1:0]    grant,
  output logic          bad_addr
);

  logic [1:0]    state_r;
  logic          last_grant_r;
  logic          owner_r;
  logic          in_range_r;

  logic          m_en_r;
  logic [3:0]    m_we_r;
  logic [AW-1:0] m_addr_r;
  logic [31:0]   m_wdata_r;

  logic          r0_ready_r;
  logic          r1_ready_r;
  logic [31:0]   r0_rdata_r;
  logic [31:0]   r1_rdata_r;
  logic [1:0]    grant_r;
  logic          bad_addr_r;

  logic [1:0]    req_s;
  logic [1:0]    pick_s;
  logic          start_s;
  logic          pick_r1_s;
  mem_req_t      sel_req_s;
  logic          sel_in_range_s;
  logic [3:0]    sel_we_s;
  logic [31:0]   cap_data_s;

  assign req_s = {r1_valid, r0_valid};

  rr_arb2 u_rr_arb2 (
    .req  (req_s),
    .last (last_grant_r),
    .gnt  (pick_s)
  );

  // Winner selection and the RAM controls it would produce if it starts now.
  always_comb begin
    start_s        = 1'b0;
    pick_r1_s      = pick_s[1];
    sel_req_s      = '{addr: r0_addr, wdata: r0_wdata, wstrb: r0_wstrb};
    sel_in_range_s = 1'b0;
    sel_we_s       = WSTRB_READ;
    if (pick_r1_s) begin
      sel_req_s = '{addr: r1_addr, wdata: r1_wdata, wstrb: r1_wstrb};
    end else begin
      sel_req_s = '{addr: r0_addr, wdata: r0_wdata, wstrb: r0_wstrb};
    end
    sel_in_range_s = word_in_range(sel_req_s.addr, 32'(MEM_SIZE));
    if (sel_in_range_s) begin
      sel_we_s = sel_req_s.wstrb;
    end else begin
      sel_we_s = WSTRB_READ;
    end
    if ((state_r == ST_IDLE) && (pick_s != GNT_NONE)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Out-of-range accesses return zero so a core addressing past the RAM still completes.
  always_comb begin
    cap_data_s = 32'h0000_0000;
    if (in_range_r) begin
      cap_data_s = m_rdata;
    end else begin
      cap_data_s = 32'h0000_0000;
    end
  end

  // Access sequencer: waits in IDLE for a request, then steps once per cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE:   state_r <= ST_CAPTURE;
        ST_CAPTURE: state_r <= ST_DONE;
        ST_DONE:    state_r <= ST_IDLE;
        default:    state_r <= ST_IDLE;
      endcase
    end
  end

  // Owner, range flag and contention history, captured once when an access starts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_r      <= 1'b0;
      in_range_r   <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (start_s) begin
      owner_r    <= pick_r1_s;
      in_range_r <= sel_in_range_s;
      if (req_s == 2'b11) begin
        last_grant_r <= pick_r1_s;
      end
    end
  end

  // RAM port: loaded from the winning request on entry to ISSUE, cleared on exit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_en_r    <= 1'b0;
      m_we_r    <= 4'b0000;
      m_addr_r  <= '0;
      m_wdata_r <= 32'h0000_0000;
    end else if (start_s) begin
      m_en_r    <= sel_in_range_s;
      m_we_r    <= sel_we_s;
      m_addr_r  <= sel_req_s.addr[AW+1:2];
      m_wdata_r <= sel_req_s.wdata;
    end else begin
      m_en_r    <= 1'b0;
      m_we_r    <= 4'b0000;
      m_addr_r  <= '0;
      m_wdata_r <= 32'h0000_0000;
    end
  end

  // Response path: owner's rdata/ready and the range error in CAPTURE, cleared leaving DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r0_ready_r <= 1'b0;
      r1_ready_r <= 1'b0;
      r0_rdata_r <= 32'h0000_0000;
      r1_rdata_r <= 32'h0000_0000;
      grant_r    <= GNT_NONE;
      bad_addr_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            grant_r <= pick_s;
          end
        end
        ST_ISSUE: begin
          grant_r <= grant_r;
        end
        ST_CAPTURE: begin
          if (owner_r) begin
            r1_rdata_r <= cap_data_s;
            r1_ready_r <= 1'b1;
          end else begin
            r0_rdata_r <= cap_data_s;
            r0_ready_r <= 1'b1;
          end
          bad_addr_r <= !in_range_r;
        end
        ST_DONE: begin
          r0_ready_r <= 1'b0;
          r1_ready_r <= 1'b0;
          bad_addr_r <= 1'b0;
          grant_r    <= GNT_NONE;
        end
        default: begin
          r0_ready_r <= 1'b0;
          r1_ready_r <= 1'b0;
          bad_addr_r <= 1'b0;
          grant_r    <= GNT_NONE;
        end
      endcase
    end
  end

  assign r0_ready = r0_ready_r;
  assign r1_ready = r1_ready_r;
  assign r0_rdata = r0_rdata_r;
  assign r1_rdata = r1_rdata_r;
  assign m_en     = m_en_r;
  assign m_we     = m_we_r;
  assign m_addr   = m_addr_r;
  assign m_wdata  = m_wdata_r;
  assign grant    = grant_r;
  assign bad_addr = bad_addr_r;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: directed scenarios then randomized traffic,
// each access checked cycle by cycle against a transaction-level model.
module tb_shared_mem_arbiter;

  localparam int MEM_SIZE = 4096;
  localparam int AW       = $clog2(MEM_SIZE);

  logic          clk = 1'b0;
  logic          resetn;
  logic          r0_valid, r1_valid;
  logic [31:0]   r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic [3:0]    r0_wstrb, r1_wstrb;
  logic          r0_ready, r1_ready;
  logic [31:0]   r0_rdata, r1_rdata;
  logic          m_en;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic [1:0]    grant;
  logic          bad_addr;

  int tests = 0;
  int fails = 0;

  // RAM attached to the arbiter, and the reference model's view of memory.
  logic [31:0] ram     [MEM_SIZE];
  logic [31:0] ref_mem [MEM_SIZE];
  int          ram_writes = 0;
  int          exp_writes = 0;
  logic        ref_last;

  // Pending request per requester and the rdata each one should be holding.
  logic        pv [2];
  logic [31:0] pa [2];
  logic [31:0] pw [2];
  logic [3:0]  ps [2];
  logic [31:0] held_rdata [2];

  shared_mem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
    .r0_ready(r0_ready), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
    .r1_ready(r1_ready), .r1_rdata(r1_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .grant(grant), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM with byte enables; counts write cycles.
  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= ram[m_addr];
      for (int b = 0; b < 4; b++) begin
        if (m_we[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end
      if (m_we != 4'b0000) ram_writes <= ram_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_ports(input logic r);
    if (r) begin
      r1_valid = pv[1]; r1_addr = pa[1]; r1_wdata = pw[1]; r1_wstrb = ps[1];
    end else begin
      r0_valid = pv[0]; r0_addr = pa[0]; r0_wdata = pw[0]; r0_wstrb = ps[0];
    end
  endtask

  task automatic post(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    pv[r] = 1'b1; pa[r] = a; pw[r] = d; ps[r] = s;
    drive_ports(r);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [29:0] wd;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      wd = 30'h3FFF_FFFC;
    else if (sel < 3)  wd = 30'(MEM_SIZE) + 30'($urandom_range(0, 1000));
    else if (sel < 4)  wd = 30'($urandom_range(0, MEM_SIZE - 1));
    else               wd = 30'($urandom_range(0, 15));
    return {wd, 2'($urandom_range(0, 3))};
  endfunction

  function automatic logic [3:0] rand_strb();
    if ($urandom_range(0, 1) == 0) return 4'b0000;
    return 4'($urandom_range(1, 15));
  endfunction

  // Serve one access. Called on a negedge while the DUT is idle with pending
  // requests on the ports; returns on the negedge after the DONE cycle.
  task automatic serve_one(input logic keep, input logic drop_cap, input string tag);
    logic        o, oth, both, inr;
    logic [AW-1:0] w;
    logic [31:0] exp_rd;
    logic [1:0]  exp_gnt;
    both = pv[0] && pv[1];
    if (both) o = ref_last ? 1'b0 : 1'b1;
    else      o = pv[1];
    if (both) ref_last = o;
    oth     = !o;
    exp_gnt = o ? 2'b10 : 2'b01;
    inr     = (pa[o][31:2] < 30'(MEM_SIZE));
    w       = pa[o][AW+1:2];
    exp_rd  = inr ? ref_mem[w] : 32'h0;
    if (inr && ps[o] != 4'b0000) begin
      for (int b = 0; b < 4; b++) if (ps[o][b]) ref_mem[w][8*b +: 8] = pw[o][8*b +: 8];
      exp_writes++;
    end
    @(posedge clk); @(negedge clk);  // ISSUE
    check({tag, " issue grant"}, 32'(grant), 32'(exp_gnt));
    check({tag, " issue m_en"},  32'(m_en), 32'(inr));
    check({tag, " issue m_we"},  32'(m_we), 32'(inr ? ps[o] : 4'b0000));
    check({tag, " issue m_addr"}, 32'(m_addr), 32'(w));
    check({tag, " issue m_wdata"}, m_wdata, pw[o]);
    check({tag, " issue ready"}, 32'({r1_ready, r0_ready}), 32'h0);
    if (o) begin r1_addr = $urandom; r1_wdata = $urandom; r1_wstrb = 4'($urandom); end
    else   begin r0_addr = $urandom; r0_wdata = $urandom; r0_wstrb = 4'($urandom); end
    @(negedge clk);  // CAPTURE
    check({tag, " capture ram port"}, 32'({m_en, m_we, m_addr}), 32'h0);
    check({tag, " capture m_wdata"}, m_wdata, 32'h0);
    check({tag, " capture ready"}, 32'({r1_ready, r0_ready, bad_addr}), 32'h0);
    check({tag, " capture grant"}, 32'(grant), 32'(exp_gnt));
    if (drop_cap) begin
      pv[o] = 1'b0;
      if (o) r1_valid = 1'b0; else r0_valid = 1'b0;
    end
    @(negedge clk);  // DONE
    check({tag, " done ready"}, 32'({r1_ready, r0_ready}), 32'(exp_gnt));
    check({tag, " done rdata"}, o ? r1_rdata : r0_rdata, exp_rd);
    check({tag, " other rdata held"}, oth ? r1_rdata : r0_rdata, held_rdata[oth]);
    check({tag, " done bad_addr"}, 32'(bad_addr), 32'(!inr));
    check({tag, " done grant"}, 32'(grant), 32'(exp_gnt));
    held_rdata[o] = exp_rd;
    if (!keep) pv[o] = 1'b0;
    drive_ports(o);
    @(negedge clk);  // back in IDLE
    check({tag, " idle outputs"}, 32'({r1_ready, r0_ready, bad_addr, grant, m_en, m_we}), 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    r0_valid = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0; r0_wstrb = 4'h0;
    r1_valid = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0; r1_wstrb = 4'h0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pa[i] = 32'h0; pw[i] = 32'h0; ps[i] = 4'h0; held_rdata[i] = 32'h0;
    end
    for (int i = 0; i < MEM_SIZE; i++) begin
      ram[i] = 32'hA500_0000 ^ 32'(i);
      ref_mem[i] = 32'hA500_0000 ^ 32'(i);
    end
    ref_last = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ctl", 32'({r1_ready, r0_ready, bad_addr, grant, m_en, m_we}), 32'h0);
    check("reset m_addr/wdata", m_wdata | 32'(m_addr), 32'h0);
    check("reset rdata", r0_rdata | r1_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Continuous contention from reset: 0,1,0,1
    post(1'b0, 32'h0000_0050, 32'h0, 4'h0);
    post(1'b1, 32'h0000_0054, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) serve_one(1'b1, 1'b0, "rr");
    pv[0] = 1'b0; pv[1] = 1'b0; drive_ports(1'b0); drive_ports(1'b1);

    // Write then read back by the other requester
    post(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    serve_one(1'b0, 1'b0, "wr0");
    post(1'b1, 32'h0000_0010, 32'h0, 4'h0);
    serve_one(1'b0, 1'b0, "rd1");
    check("readback", r1_rdata, 32'hDEAD_BEEF);

    // Byte-lane write merge
    post(1'b0, 32'h0000_0020, 32'h1122_3344, 4'hF);
    serve_one(1'b0, 1'b0, "full");
    post(1'b0, 32'h0000_0020, 32'h00AB_0000, 4'b0100);
    serve_one(1'b0, 1'b0, "byte");
    post(1'b1, 32'h0000_0020, 32'h0, 4'h0);
    serve_one(1'b0, 1'b0, "merge");
    check("merged word", r1_rdata, 32'h11AB_3344);

    // First word past the end
    post(1'b1, 32'h0000_4000, 32'h0, 4'h0);
    serve_one(1'b0, 1'b0, "oor");

    // Reset during ISSUE of a write to word 2
    post(1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); @(negedge clk);
    check("pre-reset m_we", 32'(m_we), 32'hF);
    #1 resetn = 1'b0;
    #1 check("async reset ctl", 32'({r1_ready, r0_ready, bad_addr, grant, m_en, m_we}), 32'h0);
    pv[0] = 1'b0; drive_ports(1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset no ready", 32'({r1_ready, r0_ready, m_en}), 32'h0);
    end
    check("word 2 unchanged", ram[2], ref_mem[2]);
    ref_last = 1'b1; held_rdata[0] = 32'h0; held_rdata[1] = 32'h0;
    resetn = 1'b1;
    @(negedge clk);

    // Contention after reset: r0 first, and it drops valid during CAPTURE
    post(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    post(1'b1, 32'h0000_0018, 32'h0, 4'h0);
    serve_one(1'b0, 1'b1, "drop");
    serve_one(1'b0, 1'b0, "after drop");

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 1) == 1) post(r[0], rand_addr(), $urandom, rand_strb());
      end
      if (!pv[0] && !pv[1]) post(1'($urandom_range(0, 1)), rand_addr(), $urandom, rand_strb());
      serve_one(1'b0, ($urandom_range(0, 7) == 0), "rnd");
    end

    check("ram write count", 32'(ram_writes), 32'(exp_writes));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
